// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer: FSM states and the bit layout
// of the configuration and status bytes.
package interval_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CFG_EN_BIT      = 7;
  localparam int CFG_RELOAD_BIT  = 6;
  localparam int CFG_PERIOD_MSB  = 5;
  localparam int CFG_PERIOD_LSB  = 0;
  localparam int PERIOD_FIELD_W  = CFG_PERIOD_MSB - CFG_PERIOD_LSB + 1;

  localparam int STAT_BUSY_BIT   = 7;
  localparam int STAT_DONE_BIT   = 6;

endpackage

// File: rtl/interval_timer_if.sv
// CPU-facing port group of the interval timer: config byte, interrupt
// acknowledge, interrupt request and status byte.
interface interval_timer_if;
  logic [7:0] cfg;
  logic       ack;
  logic       irq;
  logic [7:0] status;

  modport master (output cfg, output ack, input irq, input status);
  modport slave  (input cfg, input ack, output irq, output status);
endinterface

// File: rtl/interval_timer_prescaler.sv
// Tick prescaler: counts clk cycles while run=1 and pulses tick on the
// cycle the count wraps; held at zero whenever run=0.
module tick_prescaler #(
  parameter int PRESCALE = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = $clog2(PRESCALE);

  logic [CNT_W-1:0] r_cnt;

  assign tick = run && (r_cnt == CNT_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!run || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Interval timer with one-shot / auto-reload modes and an interrupt output.
// Define INTERVAL_TIMER_IRQ_LATCH_EN for a sticky irq cleared by ack.
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int PRESCALE = 10,
  parameter int PERIOD_W = 6
) (
  input logic             clk,
  input logic             reset,
  interval_timer_if.slave bus
);

  state_e              r_state, w_state_nxt;
  logic [7:0]          r_cfg_q;
  logic [PERIOD_W-1:0] r_count, w_count_nxt;
  logic                r_irq, w_irq_nxt;
  logic [7:0]          r_status, w_status_nxt;

  logic                w_en, w_reload, w_change, w_run, w_tick, w_expire;
  logic [PERIOD_W-1:0] w_period;

  assign w_en     = bus.cfg[CFG_EN_BIT];
  assign w_reload = bus.cfg[CFG_RELOAD_BIT];
  assign w_period = PERIOD_W'(bus.cfg[CFG_PERIOD_MSB:CFG_PERIOD_LSB]);
  assign w_change = (bus.cfg != r_cfg_q);

  // Prescaler restarts from zero on any restart or abort, not only on leaving RUN
  assign w_run = (r_state == ST_RUN) && w_en && !w_change;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (w_run),
    .tick  (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_expire    = 1'b0;
    if (!w_en) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
    end else if ((r_state == ST_IDLE) || w_change) begin
      if (w_period != '0) begin
        w_state_nxt = ST_RUN;
        w_count_nxt = w_period;
      end else begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
      end
    end else if ((r_state == ST_RUN) && w_tick) begin
      if (r_count == PERIOD_W'(1)) begin
        w_expire = 1'b1;
        if (w_reload) begin
          w_count_nxt = w_period;
        end else begin
          w_count_nxt = '0;
          w_state_nxt = ST_DONE;
        end
      end else begin
        w_count_nxt = r_count - PERIOD_W'(1);
      end
    end

`ifdef INTERVAL_TIMER_IRQ_LATCH_EN
    w_irq_nxt = w_en && (w_expire || (r_irq && !bus.ack));
`else
    w_irq_nxt = w_expire;
`endif

    w_status_nxt                = '0;
    w_status_nxt[STAT_BUSY_BIT] = (w_state_nxt == ST_RUN);
    w_status_nxt[STAT_DONE_BIT] = (w_state_nxt == ST_DONE);
    w_status_nxt[PERIOD_FIELD_W-1:0] = PERIOD_FIELD_W'(w_count_nxt);
  end

`ifndef INTERVAL_TIMER_IRQ_LATCH_EN
  logic w_unused_ack;
  assign w_unused_ack = bus.ack;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cfg_q  <= '0;
      r_count  <= '0;
      r_irq    <= 1'b0;
      r_status <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cfg_q  <= bus.cfg;
      r_count  <= w_count_nxt;
      r_irq    <= w_irq_nxt;
      r_status <= w_status_nxt;
    end
  end

  assign bus.irq    = r_irq;
  assign bus.status = r_status;

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboard bench for interval_timer (PRESCALE=4): directed scenarios plus
// randomized cfg/ack traffic checked against an elapsed-time reference model.
module tb_interval_timer;

  localparam int P = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  interval_timer_if bus_if ();

  interval_timer #(.PRESCALE(P), .PERIOD_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       irq;
    logic [7:0] status;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   irq_cnt  = 0;

  // Reference model: timer position expressed as cycles elapsed since start
  localparam int M_IDLE = 0, M_ACT = 1, M_DONE = 2;
  int         m_mode;
  int         m_j;
  int         m_n;
  bit         m_rl;
  logic [7:0] m_prev;
  logic       m_irq;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_j    = 0;
    m_n    = 0;
    m_rl   = 1'b0;
    m_prev = 8'h00;
    m_irq  = 1'b0;
  endfunction

  function automatic void model_edge(input logic [7:0] c, input logic a);
    bit         exp_now;
    logic [7:0] st;
    exp_t       e;
    exp_now = 1'b0;
    if (!c[7]) begin
      m_mode = M_IDLE;
      m_irq  = 1'b0;
    end else begin
      if (m_mode == M_IDLE || c != m_prev) begin
        if (c[5:0] != 6'd0) begin
          m_mode = M_ACT;
          m_j    = 0;
          m_n    = int'(c[5:0]);
          m_rl   = c[6];
        end else begin
          m_mode = M_IDLE;
        end
      end else if (m_mode == M_ACT) begin
        m_j++;
        if (m_j % (m_n * P) == 0) begin
          exp_now = 1'b1;
          if (!m_rl) m_mode = M_DONE;
        end
      end
`ifdef INTERVAL_TIMER_IRQ_LATCH_EN
      m_irq = exp_now || (m_irq && !a);
`else
      m_irq = exp_now;
`endif
    end
    m_prev = c;
    case (m_mode)
      M_ACT:   st = {2'b10, 6'(m_n - ((m_j / P) % m_n))};
      M_DONE:  st = 8'h40;
      default: st = 8'h00;
    endcase
    e.irq    = m_irq;
    e.status = st;
    sb_q.push_back(e);
  endfunction

  task automatic drive_now(input logic [7:0] c, input logic a);
    bus_if.cfg = c;
    bus_if.ack = a;
    model_edge(c, a);
  endtask

  task automatic step(input logic [7:0] c, input logic a);
    @(negedge clk);
    drive_now(c, a);
  endtask

  task automatic async_reset_pulse();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_status", {1'b0, bus_if.status}, 9'h000);
    check("async_rst_irq", {8'h00, bus_if.irq}, 9'h000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    drive_now(bus_if.cfg, 1'b0);
  endtask

  // Monitor: every clock edge with a prediction queued is an output to check
  always @(posedge clk) begin
    #1;
    if (reset && bus_if.irq) irq_cnt++;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("irq", {8'h00, bus_if.irq}, {8'h00, mon_e.irq});
      check("status", {1'b0, bus_if.status}, {1'b0, mon_e.status});
    end
  end

  initial begin
    logic [7:0] rc;
    bus_if.cfg = 8'hC3;
    bus_if.ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_status", {1'b0, bus_if.status}, 9'h000);
    check("reset_irq", {8'h00, bus_if.irq}, 9'h000);

    // Periodic, PERIOD=3 held through reset release
    reset = 1'b1;
    irq_cnt = 0;
    drive_now(8'hC3, 1'b0);
    repeat (36) step(8'hC3, 1'b0);
    @(posedge clk);
    #2;
`ifdef INTERVAL_TIMER_IRQ_LATCH_EN
    check("periodic_irq_cycles", 9'(irq_cnt), 9'd25);
`else
    check("periodic_irq_cycles", 9'(irq_cnt), 9'd3);
`endif
    check("periodic_reload_status", {1'b0, bus_if.status}, 9'h083);

    // One-shot, PERIOD=2
    repeat (9) step(8'h82, 1'b1);
    @(posedge clk);
    #2;
    check("oneshot_done_status", {1'b0, bus_if.status}, 9'h040);
    repeat (4) step(8'h82, 1'b0);
    step(8'h00, 1'b0);
    @(posedge clk);
    #2;
    check("oneshot_disable_status", {1'b0, bus_if.status}, 9'h000);

    // Abort landing exactly on the expiry edge
    irq_cnt = 0;
    repeat (8) step(8'hC2, 1'b1);
    repeat (4) step(8'h00, 1'b0);
    check("abort_no_irq", 9'(irq_cnt), 9'd0);

    // Restart before expiry
    repeat (6) step(8'hC5, 1'b0);
    repeat (30) step(8'hC2, 1'b1);

    // Reset mid-run with cfg held
    repeat (5) step(8'hC3, 1'b0);
    async_reset_pulse();
    repeat (20) step(8'hC3, 1'b0);

    // Latch-mode style ack traffic with a short period
    repeat (20) step(8'hC1, 1'b0);
    repeat (20) step(8'hC1, 1'b1);

    // Randomized traffic
    rc = 8'hC3;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(19) == 0) begin
        rc[7]   = ($urandom_range(7) != 0);
        rc[6]   = 1'($urandom_range(1));
        rc[5:0] = 6'($urandom_range(5));
      end
      if ($urandom_range(299) == 0) async_reset_pulse();
      else step(rc, ($urandom_range(3) == 0));
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", 9'(sb_q.size()), 9'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 Parameter PRESCALE, default 10: clk cycles per timer tick; legal range 2..255.
REQ-002 Parameter PERIOD_W, default 6: width of the period/count field.
REQ-003 clk  input  1  system clock; every state element updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-low; 0 = in reset.
REQ-005 cfg  input  8  configuration byte, driven from a CPU output port. Fields are cfg[7] EN, cfg[6] RELOAD, cfg[5:0] PERIOD (in ticks).
REQ-006 ack  input  1  interrupt acknowledge; used only in latch mode (REQ-020).
REQ-007 irq  output  1  interrupt request to a CPU interrupt line.
REQ-008 status  output  8  {busy, done, count[5:0]}, read back through a CPU input port.

Function
REQ-009 The block SHALL register cfg into cfg_q every cycle. A cycle where cfg != cfg_q is a "cfg change".
REQ-010 The FSM SHALL have three states:
- IDLE: count=0, prescaler=0.
- RUN: counting.
- DONE: one-shot expired.
REQ-011 Any edge that samples EN=0 SHALL force IDLE from any state, clearing count, prescaler and irq. This overrides every other event.
REQ-012 In IDLE, sampling EN=1 with PERIOD!=0 SHALL load count=PERIOD and prescaler=0, and enter RUN. PERIOD=0 SHALL leave the block in IDLE.
REQ-013 In RUN, the prescaler SHALL increment every cycle. At prescaler==PRESCALE-1 it SHALL wrap to 0 and produce a tick. Each tick SHALL decrement count.
REQ-014 Expiry is a tick with count==1. On expiry:
- irq SHALL be registered high for exactly the following cycle.
- With RELOAD=1: count reloads PERIOD and the state stays RUN.
- With RELOAD=0: count becomes 0 and the state becomes DONE.
REQ-015 Latency: if EN=1, PERIOD=N is first sampled at edge k, the first irq SHALL be high from edge k+N*PRESCALE to edge k+N*PRESCALE+1. In reload mode irq SHALL then repeat every N*PRESCALE cycles.
REQ-016 A cfg change with EN=1 while in RUN or DONE SHALL restart the timer exactly as in REQ-012. The restart takes priority over a coincident expiry, so no irq is generated on that edge.
REQ-017 DONE SHALL hold count=0 and irq=0 until EN=0 or a cfg change.
REQ-018 status SHALL be registered. busy=1 only in RUN; done=1 only in DONE; status[5:0] = count.

Reset
REQ-019 While reset=0, the block SHALL hold all of the following, asynchronously: state=IDLE, cfg_q=0, count=0, prescaler=0, irq=0, status=8'h00. A nonzero cfg present at reset release SHALL be treated as a cfg change on the first edge.

Configuration
REQ-020 Macro INTERVAL_TIMER_IRQ_LATCH_EN SHALL select the irq behaviour:
- Defined: irq is sticky. It sets on expiry and clears on the edge after ack=1 is sampled. An expiry coincident with ack keeps irq=1. EN=0 and reset still clear it.
- Undefined: irq is the one-cycle pulse of REQ-014, and ack is ignored.

Structure
REQ-021 Package interval_timer_pkg SHALL hold:
- the FSM state enum;
- the cfg field bit positions (EN=7, RELOAD=6, PERIOD=5:0);
- the status bit positions (busy=7, done=6).
REQ-022 The prescaler SHALL be a sub-module tick_prescaler(clk, reset, run, tick). It counts only while run=1, clears when run=0, and pulses tick at wrap.

Verification (PRESCALE=4)
REQ-023 Periodic: release reset, then cfg=8'hC3. irq pulses occur at 12, 24 and 36 cycles after the sampling edge. status reads 8'h83, 8'h82, 8'h81, then 8'h83 after reload.
REQ-024 One-shot: cfg=8'h82. A single irq occurs at +8 cycles, then status=8'h40 and stays there. Setting cfg=8'h00 gives status=8'h00 on the next edge.
REQ-025 Abort: cfg=8'hC2, then cfg=8'h00 applied so that it is sampled at the expiry edge. Result: no irq, status=8'h00.
REQ-026 Restart: cfg=8'hC5, then cfg=8'hC2 at +6 cycles. The next irq occurs 8 cycles after the change edge, with no irq at the original +20.
REQ-027 Reset mid-run: reset=0 at +5 cycles. status and irq go to 0 immediately, without waiting for a clk edge. After release with cfg=8'hC3 held, the first irq occurs 12 cycles after the first edge.
REQ-028 Latch mode (macro defined): cfg=8'hC1. irq rises at +4 and stays high until ack=1 is sampled. If ack=1 coincides with the next expiry edge, irq stays 1.
